// File: rtl/dcache_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   dc_op_t    : operation latched at request acceptance
//   dc_state_t : responder FSM states
//   DC_WORD_BYTES : bytes per stored word (addresses are byte addresses)
//   dc_decode_op  : turns the ReadEn/WriteEn pair into an operation
package dcache_responder_pkg;

  localparam int DC_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    DC_OP_NONE  = 2'd0,
    DC_OP_LOAD  = 2'd1,
    DC_OP_STORE = 2'd2
  } dc_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dc_state_t;

  // Load wins over store so a requester may tie WriteEn high.
  function automatic dc_op_t dc_decode_op(input logic read_en, input logic write_en);
    if (read_en) begin
      return DC_OP_LOAD;
    end else if (write_en) begin
      return DC_OP_STORE;
    end
    return DC_OP_NONE;
  endfunction

endpackage

// File: rtl/dcache_responder_if.sv
// dCache request/response bundle between the memory-access stage and the
// data-memory responder.
//   master : requester side (drives request, address, enables, store data)
//   slave  : responder side (drives read data, busy, done, error)
interface dcache_responder_if;

  logic        dCacheReq;
  logic [31:0] dCacheAddr;
  logic        dCacheWriteEn;
  logic        dCacheReadEn;
  logic [31:0] dCacheWriteData;
  logic [31:0] dCacheReadData;
  logic        dCacheBusy;
  logic        dCacheDone;
  logic        dCacheErr;

  modport master (
    output dCacheReq, dCacheAddr, dCacheWriteEn, dCacheReadEn, dCacheWriteData,
    input  dCacheReadData, dCacheBusy, dCacheDone, dCacheErr
  );

  modport slave (
    input  dCacheReq, dCacheAddr, dCacheWriteEn, dCacheReadEn, dCacheWriteData,
    output dCacheReadData, dCacheBusy, dCacheDone, dCacheErr
  );

endinterface

// File: rtl/dcache_responder_dmem_array.sv
// dmem_array: DEPTH x 32 single-port word storage.
//   clk   : write and read clock
//   rst_n : async active-low reset of the read register only
//   en    : access enable for this edge
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read
module dmem_array #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM; only the
  // output register is cleared.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: memory side of the dCache interface. Accepts one load or
// store at a time, completes it LATENCY cycles after acceptance with a
// one-cycle done pulse, and flags misaligned or out-of-range addresses.
//   clk   : rising-edge clock
//   rst_n : async active-low reset; drops any pending request
//   dc    : dCache bundle, slave side
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  dcache_responder_if.slave dc
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = $clog2(LATENCY) + 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * DC_WORD_BYTES);
  localparam bit          DIRECT     = (LATENCY == 1);

  dc_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  dc_op_t        op_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          err_q;

  logic          done_q;
  logic          err_out_q;

  // Incoming request decode.
  logic          accept;
  dc_op_t        op_in;
  logic [AW-1:0] idx_in;
  logic          err_in;

  assign accept = dc.dCacheReq && (state_q != WAIT);
  assign op_in  = dc_decode_op(dc.dCacheReadEn, dc.dCacheWriteEn);
  assign idx_in = dc.dCacheAddr[AW+1:2];
  assign err_in = (dc.dCacheAddr[1:0] != 2'b00) || (dc.dCacheAddr >= ADDR_LIMIT);

  // Operation performed on the edge that enters RESP. With LATENCY=1 that
  // edge is the acceptance edge itself, so the incoming request is used
  // directly instead of the latched copy.
  logic          fire;
  dc_op_t        f_op;
  logic [AW-1:0] f_idx;
  logic [31:0]   f_wdata;
  logic          f_err;

  assign f_op    = DIRECT ? op_in              : op_q;
  assign f_idx   = DIRECT ? idx_in             : idx_q;
  assign f_wdata = DIRECT ? dc.dCacheWriteData : wdata_q;
  assign f_err   = DIRECT ? err_in             : err_q;

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d = CW'(LATENCY - 1);
          if (DIRECT) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          fire    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= DC_OP_NONE;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= fire;
      err_out_q <= fire && f_err;
      if (accept) begin
        op_q    <= op_in;
        idx_q   <= idx_in;
        wdata_q <= dc.dCacheWriteData;
        err_q   <= err_in;
      end
    end
  end

  // The storage array itself is not reset, so its enable is also held off
  // while reset is asserted; a request seen during reset must not write.
  logic mem_en;
  logic mem_we;

  assign mem_en = rst_n && fire && !f_err && (f_op != DC_OP_NONE);
  assign mem_we = (f_op == DC_OP_STORE);

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (f_idx),
    .wdata (f_wdata),
    .rdata (dc.dCacheReadData)
  );

  assign dc.dCacheBusy = (state_q == WAIT);
  assign dc.dCacheDone = done_q;
  assign dc.dCacheErr  = err_out_q;

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-memory responder for the memory-access pipeline stage.
- Accepts load/store requests on the dCache interface and completes each after a fixed, parameterised latency.
- Returns load data and a one-cycle done pulse to the stage.
- Sits between memory access and the word-addressed data storage; provides the memory side of the dCacheAddr/WriteEn/ReadEn/WriteData/ReadData interface.

Parameters:
- DEPTH, 256, number of 32-bit words stored; power of two, minimum 4.
- LATENCY, 2, cycles from request acceptance to done pulse; minimum 1.

Ports:
- clk  input  1  single clock for all state; rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- dCacheReq  input  1  request strobe, sampled on the rising edge.
- dCacheAddr  input  32  byte address.
- dCacheWriteEn  input  1  store intent; the requester may tie this high.
- dCacheReadEn  input  1  load intent; takes priority over dCacheWriteEn.
- dCacheWriteData  input  32  store data.
- dCacheReadData  output  32  load result; held until the next load completes.
- dCacheBusy  output  1  high while a request is pending (state WAIT).
- dCacheDone  output  1  one-cycle completion pulse.
- dCacheErr  output  1  valid with dCacheDone; high for a misaligned or out-of-range address.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0.
  - dCacheReadData=0, dCacheBusy=0, dCacheDone=0, dCacheErr=0.
  - Any pending request is dropped, including a pending store. Storage contents are not reset.
- Op decode at acceptance:
  - ReadEn=1 gives LOAD, regardless of WriteEn.
  - ReadEn=0 and WriteEn=1 gives STORE.
  - Both 0 gives NONE, which completes normally with no side effect.
- Address checks:
  - Word index = dCacheAddr[log2(DEPTH)+1:2].
  - Error if dCacheAddr[1:0]!=0, or if dCacheAddr >= DEPTH*4.
  - On error: no write occurs, dCacheReadData keeps its old value, dCacheErr=1 with dCacheDone.
- FSM states: IDLE, WAIT, RESP.
  - Acceptance: on an edge where dCacheReq=1 and state is IDLE or RESP. Latch op, addr, wdata and the error flag; counter=LATENCY-1.
  - After acceptance, go to RESP if LATENCY=1, else WAIT.
  - WAIT: decrement counter each edge. On the edge where counter==1, go to RESP.
  - On the edge entering RESP:
    - perform the STORE write, or register the LOAD read into dCacheReadData;
    - set dCacheDone=1 and set dCacheErr.
  - RESP: lasts exactly one cycle. Next edge goes to WAIT/RESP if a new request is accepted, else IDLE. dCacheDone and dCacheErr clear unless a LATENCY=1 request completes again.
  - dCacheReq while in WAIT is ignored. The requester must hold off while dCacheBusy=1.
- Timing:
  - Accept at edge k; dCacheDone is high in the cycle after edge k+LATENCY-1.
  - Back-to-back issue rate is one request per LATENCY cycles.
- Ordering:
  - A load accepted in the RESP cycle of a store to the same word returns the new data.
  - No forwarding is needed because the write happens before the load reads.
- Ignored inputs: WriteData for LOAD/NONE; ReadEn/WriteEn/Addr outside acceptance edges.
- Wrap-around:
  - Word index is taken exactly, with no modulo aliasing; out-of-range addresses are flagged as errors.
  - Counter width is clog2(LATENCY)+1.

Decomposition:
- Shared package (alongside the existing instruction structures):
  - dc_op_t enum: DC_OP_NONE, DC_OP_LOAD, DC_OP_STORE.
  - dc_state_t enum: IDLE, WAIT, RESP.
  - Constant DC_WORD_BYTES=4.
- One sub-module, dmem_array:
  - DEPTH x 32 storage, synchronous write, synchronous read, single port.
  - Instantiated by dcache_responder; the FSM drives its enables on the RESP-entry edge.

Test Plan:
- Reset mid-WAIT: LATENCY=3, STORE 0xDEADBEEF to addr 0x10, assert rst_n=0 one cycle after acceptance -> all outputs 0 immediately. A later LOAD of 0x10 returns the pre-reset contents, not 0xDEADBEEF.
- Basic store/load: LATENCY=2, STORE 0x12345678 to 0x20 -> Done pulses in the 2nd cycle after acceptance with Err=0. Then LOAD 0x20 -> ReadData=0x12345678.
- Priority with WriteEn tied high: WriteEn=1, ReadEn=1, addr 0x20 -> LOAD. Storage unchanged and ReadData=0x12345678.
- Back-to-back in RESP: LATENCY=1, STORE 0xA5A5A5A5 to 0x40, then LOAD 0x40 accepted in the STORE's RESP cycle -> two consecutive Done cycles; the second returns 0xA5A5A5A5.
- Errors: LOAD 0x22 (misaligned) and STORE to DEPTH*4=0x400 -> Done with Err=1. ReadData unchanged; word 0 (aliasing target) unmodified.
- Busy ignore and NONE: request during WAIT -> ignored, exactly one Done. ReadEn=0, WriteEn=0 -> Done, Err=0, no state change.
